// File: rtl/conv_pkg.sv
// Shared constants and width helpers for the K x K convolution engine.
package conv_pkg;

  localparam int unsigned DEF_K  = 5;
  localparam int unsigned DEF_DW = 8;
  localparam int unsigned DEF_KW = 8;

  // Full-precision dot-product width: one product plus log2(taps) carry bits.
  function automatic int unsigned conv_ow(input int unsigned dw, input int unsigned kw,
                                          input int unsigned k);
    return dw + kw + $clog2(k * k);
  endfunction

  // Width of adder-tree level l; iw is the product width (DW+KW for the convolver).
  function automatic int unsigned tree_w(input int unsigned iw, input int unsigned l);
    return iw + l;
  endfunction

  // Number of nodes at adder-tree level l for n leaves (ceil(n / 2^l)).
  function automatic int unsigned tree_cnt(input int unsigned n, input int unsigned l);
    return (n + (32'd1 << l) - 32'd1) >> l;
  endfunction

endpackage

// File: rtl/adder_tree_pipe.sv
// Pipelined binary adder tree: one register per level, one bit of growth per level,
// and a shared enable so the whole tree freezes under backpressure.
module adder_tree_pipe
  import conv_pkg::*;
#(
  parameter int unsigned N      = 25,
  parameter int unsigned IW     = 16,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned D     = $clog2(N),
  localparam int unsigned OW    = IW + D
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          vin,
  input  logic [N*IW-1:0] in_flat,
  output logic          vout,
  output logic [OW-1:0] sum
);

  for (genvar l = 0; l <= D; l++) begin : g_lvl
    localparam int unsigned LW  = tree_w(IW, l);
    localparam int unsigned CNT = tree_cnt(N, l);

    logic [LW-1:0] val [CNT];
    logic          vld;

    if (l == 0) begin : g_src
      // Level 0 is the unpacked view of the flat input bus.
      always_comb begin
        for (int j = 0; j < int'(N); j++) val[j] = in_flat[j*IW +: IW];
        vld = vin;
      end
    end else begin : g_add
      localparam int unsigned PCNT = tree_cnt(N, l - 1);

      logic [LW-2:0] pad   [2*CNT];
      logic [LW-1:0] sum_d [CNT];
      logic [LW-1:0] sum_q [CNT];
      logic          vld_d;
      logic          vld_q;

      // Previous level padded to an even count; the zero pad passes an odd leftover through.
      always_comb begin
        for (int j = 0; j < int'(2*CNT); j++) pad[j] = '0;
        for (int j = 0; j < int'(PCNT); j++) pad[j] = g_lvl[l-1].val[j];
      end

      // Pairwise sums, each operand widened by one bit with its own sign (or zero).
      always_comb begin
        for (int j = 0; j < int'(CNT); j++) begin
          sum_d[j] = en ? ({SIGNED & pad[2*j][LW-2], pad[2*j]} +
                           {SIGNED & pad[2*j+1][LW-2], pad[2*j+1]})
                        : sum_q[j];
        end
        vld_d = en ? g_lvl[l-1].vld : vld_q;
      end

      // Level register with its travelling valid bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int j = 0; j < int'(CNT); j++) sum_q[j] <= '0;
          vld_q <= 1'b0;
        end else begin
          for (int j = 0; j < int'(CNT); j++) sum_q[j] <= sum_d[j];
          vld_q <= vld_d;
        end
      end

      // Expose this level under the common name used by the next level.
      always_comb begin
        val = sum_q;
        vld = vld_q;
      end
    end
  end

  // The last level holds a single OW-wide node.
  always_comb begin
    vout = g_lvl[D].vld;
    sum  = g_lvl[D].val[0];
  end

endmodule

// File: rtl/conv_kxk_pipe.sv
// K x K convolution MAC: kernel register bank, registered product stage and a
// pipelined adder tree, with valid/ready handshakes and a global stall enable.
module conv_kxk_pipe
  import conv_pkg::*;
#(
  parameter int unsigned K      = DEF_K,
  parameter int unsigned DW     = DEF_DW,
  parameter int unsigned KW     = DEF_KW,
  parameter bit          SIGNED = 1'b0,
  localparam int unsigned T     = K * K,
  localparam int unsigned AW    = $clog2(T),
  localparam int unsigned OW    = conv_ow(DW, KW, K)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            k_wr_en,
  input  logic [AW-1:0]   k_wr_addr,
  input  logic [KW-1:0]   k_wr_data,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [T*DW-1:0] in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [OW-1:0]   out_data
);

  localparam int unsigned PW = DW + KW;

  logic            en;
  logic [KW-1:0]   coef_d [T];
  logic [KW-1:0]   coef_q [T];
  logic [PW-1:0]   pix_ext;
  logic [PW-1:0]   coef_ext;
  logic [T*PW-1:0] prod_d;
  logic [T*PW-1:0] prod_q;
  logic            prod_vld_d;
  logic            prod_vld_q;
  logic            tree_vld;
  logic [OW-1:0]   tree_sum;

  // The pipe only stalls while a finished result is being refused downstream.
  always_comb begin
    en       = !(out_valid && !out_ready);
    in_ready = en;
  end

  // Kernel bank update; addresses beyond the last tap are dropped.
  always_comb begin
    coef_d = coef_q;
    if (k_wr_en && ({1'b0, k_wr_addr} < (AW+1)'(T))) coef_d[k_wr_addr] = k_wr_data;
  end

  // Kernel bank registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(T); i++) coef_q[i] <= '0;
    end else begin
      for (int i = 0; i < int'(T); i++) coef_q[i] <= coef_d[i];
    end
  end

  // Product stage: both operands extended to PW so the PW-bit product is exact;
  // reads the pre-write coefficients so a same-cycle write affects the next window.
  always_comb begin
    prod_d     = prod_q;
    prod_vld_d = prod_vld_q;
    pix_ext    = '0;
    coef_ext   = '0;
    if (en) begin
      prod_vld_d = in_valid;
      if (in_valid) begin
        for (int i = 0; i < int'(T); i++) begin
          pix_ext  = {{KW{SIGNED & in_data[i*DW + DW - 1]}}, in_data[i*DW +: DW]};
          coef_ext = {{DW{SIGNED & coef_q[i][KW-1]}}, coef_q[i]};
          prod_d[i*PW +: PW] = pix_ext * coef_ext;
        end
      end
    end
  end

  // Product and valid registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
    end else begin
      prod_q     <= prod_d;
      prod_vld_q <= prod_vld_d;
    end
  end

  adder_tree_pipe #(
    .N      (T),
    .IW     (PW),
    .SIGNED (SIGNED)
  ) u_tree (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .vin     (prod_vld_q),
    .in_flat (prod_q),
    .vout    (tree_vld),
    .sum     (tree_sum)
  );

  // The final tree register is the output register.
  always_comb begin
    out_valid = tree_vld;
    out_data  = tree_sum;
  end

endmodule
